// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU op codes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Data-memory wait timer: counts cycles spent in MEM and flags the TIMEOUT-th cycle.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt_q;

    // cnt_q holds the number of completed wait cycles, so the current cycle is cnt_q+1.
    assign expire = en && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM (fetch/decode/execute/mem/writeback/halt).
// Optional retired-instruction counter enabled by macro MC_PERF_CNT_EN.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       halt_req,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       alu_src,
    output logic       mem2reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       halted
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic       expire;

    logic       imem_req_c, ir_write_c, pc_write_c, alu_src_c, mem2reg_c;
    logic       mem_read_c, mem_write_c, reg_write_c, retire_c, illegal_c;
    logic       bus_error_c, halted_c;
    logic [1:0] alu_op_c;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_MEM),
        .en     (state_q == ST_MEM),
        .expire (expire)
    );

    // Opcode is captured as DECODE is left; later states decode from the captured copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            op_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        alu_src_c   = 1'b0;
        mem2reg_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        alu_op_c    = ALU_OP_ADD;
        retire_c    = 1'b0;
        illegal_c   = 1'b0;
        bus_error_c = 1'b0;
        halted_c    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    imem_req_c = 1'b1;
                    if (imem_ready) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                alu_src_c = (op_q != OP_RTYPE);
                alu_op_c  = is_mem_op(op_q) ? ALU_OP_ADD : ALU_OP_FUNC;
                state_d   = is_mem_op(op_q) ? ST_MEM : ST_WRITEBACK;
            end
            ST_MEM: begin
                if (op_q == OP_LOAD) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
                // A ready arriving on the expiry cycle wins over the timeout.
                if (dmem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (expire) begin
                    bus_error_c = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                reg_write_c = 1'b1;
                mem2reg_c   = (op_q == OP_LOAD);
                retire_c    = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                halted_c = 1'b1;
                if (!halt_req) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Gating with reset makes every output drop the moment reset is asserted.
    assign imem_req      = reset & imem_req_c;
    assign ir_write      = reset & ir_write_c;
    assign pc_write      = reset & pc_write_c;
    assign alu_src       = reset & alu_src_c;
    assign mem2reg       = reset & mem2reg_c;
    assign mem_read      = reset & mem_read_c;
    assign mem_write     = reset & mem_write_c;
    assign reg_write     = reset & reg_write_c;
    assign alu_op        = reset ? alu_op_c : 2'b00;
    assign retire        = reset & retire_c;
    assign illegal_instr = reset & illegal_c;
    assign bus_error     = reset & bus_error_c;
    assign halted        = reset & halted_c;
    assign state         = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] retired_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt_q <= 32'd0;
        end else if (retire_c) begin
            retired_cnt_q <= retired_cnt_q + 32'd1;
        end
    end

    assign retired_count = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller (TIMEOUT=16).
module tb_multicycle_controller;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011;
    localparam logic [6:0] BAD   = 7'b1111111;

    // Packed output view: {imem_req, ir_write, pc_write, alu_src, mem2reg, mem_read,
    //                      mem_write, reg_write, alu_op[1:0], retire, illegal, bus_error, halted}
    localparam logic [13:0] NONE = 14'h0000;
    localparam logic [13:0] IMQ  = 14'h2000;
    localparam logic [13:0] IRW  = 14'h1000;
    localparam logic [13:0] PCW  = 14'h0800;
    localparam logic [13:0] ASRC = 14'h0400;
    localparam logic [13:0] M2R  = 14'h0200;
    localparam logic [13:0] MRD  = 14'h0100;
    localparam logic [13:0] MWR  = 14'h0080;
    localparam logic [13:0] RGW  = 14'h0040;
    localparam logic [13:0] AOPF = 14'h0020;
    localparam logic [13:0] RET  = 14'h0008;
    localparam logic [13:0] ILL  = 14'h0004;
    localparam logic [13:0] BER  = 14'h0002;
    localparam logic [13:0] HLT  = 14'h0001;
    localparam logic [13:0] FGO  = IMQ | IRW | PCW;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready, halt_req;
    logic       imem_req, ir_write, pc_write, alu_src, mem2reg;
    logic       mem_read, mem_write, reg_write;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic       retire, illegal_instr, bus_error, halted;
`ifdef MC_PERF_CNT_EN
    logic [31:0] retired_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0]  op;
        logic        iready;
        logic        dready;
        logic        hreq;
        logic [2:0]  st;
        logic [13:0] out;
    } vec_t;

    vec_t tbl[$];

    multicycle_controller #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .alu_src       (alu_src),
        .mem2reg       (mem2reg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_op        (alu_op),
        .state         (state),
        .retire        (retire),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .halted        (halted)
`ifdef MC_PERF_CNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] outs();
        return {imem_req, ir_write, pc_write, alu_src, mem2reg, mem_read, mem_write,
                reg_write, alu_op, retire, illegal_instr, bus_error, halted};
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic [13:0] o);
        n_cmp++;
        if (state !== st || outs() !== o) begin
            n_err++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, outs(), st, o);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check before the next rising edge.
    task automatic step(input string name, input logic [6:0] op, input logic ir,
                        input logic dr, input logic hr, input logic [2:0] st,
                        input logic [13:0] o);
        @(negedge clk);
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        halt_req   = hr;
        #1;
        check(name, st, o);
    endtask

    task automatic add(input logic [6:0] op, input logic ir, input logic dr, input logic hr,
                       input logic [2:0] st, input logic [13:0] o);
        vec_t v;
        v.op = op; v.iready = ir; v.dready = dr; v.hreq = hr; v.st = st; v.out = o;
        tbl.push_back(v);
    endtask

    initial begin
        // R-type, zero wait: 0,1,2,4 then back to FETCH
        add(R_OP, 1, 0, 0, 3'd0, FGO);
        add(R_OP, 0, 0, 0, 3'd1, NONE);
        add(R_OP, 0, 0, 0, 3'd2, AOPF);
        add(R_OP, 0, 0, 0, 3'd4, RGW | RET);
        // I-type with one imem wait cycle
        add(I_OP, 0, 0, 0, 3'd0, IMQ);
        add(I_OP, 1, 0, 0, 3'd0, FGO);
        add(I_OP, 0, 0, 0, 3'd1, NONE);
        add(I_OP, 0, 0, 0, 3'd2, ASRC | AOPF);
        add(I_OP, 0, 0, 0, 3'd4, RGW | RET);
        // LW, dmem ready on the third MEM cycle
        add(LW_OP, 1, 0, 0, 3'd0, FGO);
        add(LW_OP, 0, 0, 0, 3'd1, NONE);
        add(LW_OP, 0, 0, 0, 3'd2, ASRC);
        add(LW_OP, 0, 0, 0, 3'd3, MRD);
        add(LW_OP, 0, 0, 0, 3'd3, MRD);
        add(LW_OP, 0, 1, 0, 3'd3, MRD);
        add(LW_OP, 0, 0, 0, 3'd4, RGW | M2R | RET);
        // SW, zero wait: retire in MEM
        add(SW_OP, 1, 0, 0, 3'd0, FGO);
        add(SW_OP, 0, 0, 0, 3'd1, NONE);
        add(SW_OP, 0, 0, 0, 3'd2, ASRC);
        add(SW_OP, 0, 1, 0, 3'd3, MWR | RET);
        // Illegal opcode
        add(BAD, 1, 0, 0, 3'd0, FGO);
        add(BAD, 0, 0, 0, 3'd1, ILL);
        add(BAD, 0, 0, 0, 3'd0, IMQ);

        opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        check("reset_state", 3'd0, NONE);
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].op, tbl[i].iready, tbl[i].dready,
                 tbl[i].hreq, tbl[i].st, tbl[i].out);
        end
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        if (retired_count !== 32'd4) begin
            n_err++;
            $display("FAIL perf_after_table: got %0d, expected 4", retired_count);
        end
`endif

        // SW with dmem never ready: 16 wait cycles then bus_error, no retire
        step("sw_to_fetch", SW_OP, 1, 0, 0, 3'd0, FGO);
        step("sw_to_decode", SW_OP, 0, 0, 0, 3'd1, NONE);
        step("sw_to_exec", SW_OP, 0, 0, 0, 3'd2, ASRC);
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("sw_wait[%0d]", k), SW_OP, 0, 0, 0, 3'd3,
                 (k == 16) ? (MWR | BER) : MWR);
        end
        step("sw_timeout_fetch", SW_OP, 0, 0, 0, 3'd0, IMQ);

        // LW with ready on exactly the 16th cycle counts as success
        step("lw16_fetch", LW_OP, 1, 0, 0, 3'd0, FGO);
        step("lw16_decode", LW_OP, 0, 0, 0, 3'd1, NONE);
        step("lw16_exec", LW_OP, 0, 0, 0, 3'd2, ASRC);
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("lw16_wait[%0d]", k), LW_OP, 0, (k == 16), 0, 3'd3, MRD);
        end
        step("lw16_wb", LW_OP, 0, 0, 0, 3'd4, RGW | M2R | RET);

        // halt_req raised during EXECUTE: instruction completes, then HALT
        step("halt_fetch", R_OP, 1, 0, 0, 3'd0, FGO);
        step("halt_decode", R_OP, 0, 0, 0, 3'd1, NONE);
        step("halt_exec", R_OP, 0, 0, 1, 3'd2, AOPF);
        step("halt_wb", R_OP, 0, 0, 1, 3'd4, RGW | RET);
        step("halt_fetch_noreq", R_OP, 1, 0, 1, 3'd0, NONE);
        step("halt_hold", R_OP, 0, 0, 1, 3'd5, HLT);
        step("halt_release", R_OP, 0, 0, 0, 3'd5, HLT);
        step("halt_resume", R_OP, 0, 0, 0, 3'd0, IMQ);

        // Reset asserted in the middle of MEM
        step("rst_fetch", SW_OP, 1, 0, 0, 3'd0, FGO);
        step("rst_decode", SW_OP, 0, 0, 0, 3'd1, NONE);
        step("rst_exec", SW_OP, 0, 0, 0, 3'd2, ASRC);
        step("rst_mem1", SW_OP, 0, 0, 0, 3'd3, MWR);
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        if (retired_count !== 32'd6) begin
            n_err++;
            $display("FAIL perf_before_reset: got %0d, expected 6", retired_count);
        end
`endif
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async", 3'd0, NONE);
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        if (retired_count !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d, expected 0", retired_count);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        step("rst_resume", R_OP, 0, 0, 0, 3'd0, IMQ);
        step("rst_resume_go", R_OP, 1, 0, 0, 3'd0, FGO);
        step("rst_resume_dec", R_OP, 0, 0, 0, 3'd1, NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
